// File: rtl/alimentador_rolha.sv
// Cork magazine/feeder controller: tracks stock, requests refills, flags underflow/overfill.
// Optional `define ROLHA_TOTAL_EN adds a 16-bit saturating count of successful withdrawals.
module alimentador_rolha #(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 200,
  parameter int LOW_MARK = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ve,
  input  logic             carga,
  input  logic [WIDTH-1:0] qtd_carga,
  output logic             rolha,
  output logic             baixo,
  output logic             pedido,
  output logic [WIDTH-1:0] estoque,
  output logic             erro,
  output logic             excesso
`ifdef ROLHA_TOTAL_EN
  ,
  output logic [15:0]      total
`endif
);

  localparam logic [1:0] VAZIO  = 2'd0;
  localparam logic [1:0] BAIXO  = 2'd1;
  localparam logic [1:0] NORMAL = 2'd2;

  localparam logic [WIDTH:0]   CAP   = (WIDTH+1)'(CAPACITY);
  localparam logic [WIDTH-1:0] LOW_W = WIDTH'(LOW_MARK);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH:0]   soma_raw;
  logic [WIDTH:0]   soma;
  logic             sat;
  logic             retira;
  logic             under;
  logic [WIDTH-1:0] estoque_next;
  logic             pedido_next;
  logic             erro_next;

  // Load is applied before the withdrawal; one extra bit keeps the sum exact before clamping.
  always_comb begin
    soma_raw = {1'b0, estoque} + (carga ? {1'b0, qtd_carga} : '0);
    sat      = (soma_raw > CAP);
    soma     = sat ? CAP : soma_raw;
    retira   = ve && (soma != '0);
    under    = ve && (soma == '0);

    estoque_next = retira ? (soma[WIDTH-1:0] - ONE_W) : soma[WIDTH-1:0];

    if (estoque_next == '0)
      state_next = VAZIO;
    else if (estoque_next <= LOW_W)
      state_next = BAIXO;
    else
      state_next = NORMAL;

    if (state_next != NORMAL)
      pedido_next = 1'b1;
    else if (carga)
      pedido_next = 1'b0;
    else
      pedido_next = pedido;

    // Underflow wins over a clearing load in the same cycle.
    if (under)
      erro_next = 1'b1;
    else if (carga && (estoque_next != '0))
      erro_next = 1'b0;
    else
      erro_next = erro;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estoque <= '0;
      state   <= VAZIO;
      pedido  <= 1'b1;
      erro    <= 1'b0;
      excesso <= 1'b0;
    end else begin
      estoque <= estoque_next;
      state   <= state_next;
      pedido  <= pedido_next;
      erro    <= erro_next;
      excesso <= sat;
    end
  end

`ifdef ROLHA_TOTAL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      total <= 16'd0;
    else if (retira && (total != 16'hFFFF))
      total <= total + 16'd1;
  end
`endif

  assign rolha = (state != VAZIO);
  assign baixo = (state != NORMAL);

endmodule

// File: tb/tb_alimentador_rolha.sv
// Directed bench for alimentador_rolha: hand-computed stock/flag expectations per cycle.
// Covers reset, load, withdrawal, low mark, underflow, overfill, simultaneous ops and async reset.
module tb_alimentador_rolha;

  logic       clk;
  logic       reset;
  logic       ve;
  logic       carga;
  logic [7:0] qtd_carga;
  logic       rolha;
  logic       baixo;
  logic       pedido;
  logic [7:0] estoque;
  logic       erro;
  logic       excesso;
`ifdef ROLHA_TOTAL_EN
  logic [15:0] total;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  alimentador_rolha #(.WIDTH(8), .CAPACITY(200), .LOW_MARK(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .ve        (ve),
    .carga     (carga),
    .qtd_carga (qtd_carga),
    .rolha     (rolha),
    .baixo     (baixo),
    .pedido    (pedido),
    .estoque   (estoque),
    .erro      (erro),
    .excesso   (excesso)
`ifdef ROLHA_TOTAL_EN
    ,
    .total     (total)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge.
  task automatic step(input logic v, input logic c, input logic [7:0] q);
    ve = v; carga = c; qtd_carga = q;
    @(posedge clk);
    #1;
    ve = 1'b0; carga = 1'b0; qtd_carga = 8'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_estoque"}, 32'(estoque), 32'd0);
    check({tag, "_rolha"},   32'(rolha),   32'd0);
    check({tag, "_baixo"},   32'(baixo),   32'd1);
    check({tag, "_pedido"},  32'(pedido),  32'd1);
    check({tag, "_erro"},    32'(erro),    32'd0);
    check({tag, "_excesso"}, 32'(excesso), 32'd0);
`ifdef ROLHA_TOTAL_EN
    check({tag, "_total"},   32'(total),   32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; ve = 1'b0; carga = 1'b0; qtd_carga = 8'd0;
    #3;
    check_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b0;

    // load 50 -> NORMAL
    step(1'b0, 1'b1, 8'd50);
    check("load50_estoque", 32'(estoque), 32'd50);
    check("load50_rolha",   32'(rolha),   32'd1);
    check("load50_baixo",   32'(baixo),   32'd0);
    check("load50_pedido",  32'(pedido),  32'd0);

    // 29 withdrawals stay above the low mark, the 30th reaches it
    for (int i = 0; i < 29; i++) step(1'b1, 1'b0, 8'd0);
    check("ve29_estoque", 32'(estoque), 32'd21);
    check("ve29_baixo",   32'(baixo),   32'd0);
    check("ve29_pedido",  32'(pedido),  32'd0);
    step(1'b1, 1'b0, 8'd0);
    check("ve30_estoque", 32'(estoque), 32'd20);
    check("ve30_baixo",   32'(baixo),   32'd1);
    check("ve30_pedido",  32'(pedido),  32'd1);
    check("ve30_rolha",   32'(rolha),   32'd1);

    // drain to 1, then empty, then underflow
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 8'd0);
    check("drain_estoque", 32'(estoque), 32'd1);
    step(1'b1, 1'b0, 8'd0);
    check("empty_estoque", 32'(estoque), 32'd0);
    check("empty_rolha",   32'(rolha),   32'd0);
    check("empty_erro",    32'(erro),    32'd0);
    step(1'b1, 1'b0, 8'd0);
    check("under_erro",    32'(erro),    32'd1);
    check("under_estoque", 32'(estoque), 32'd0);
    step(1'b0, 1'b1, 8'd3);
    check("load3_erro",    32'(erro),    32'd0);
    check("load3_estoque", 32'(estoque), 32'd3);
    check("load3_pedido",  32'(pedido),  32'd1);
    check("load3_rolha",   32'(rolha),   32'd1);

    // overfill: 190 + 30 clamps to 200 with a one-cycle pulse
    step(1'b0, 1'b1, 8'd187);
    check("load187_estoque", 32'(estoque), 32'd190);
    check("load187_excesso", 32'(excesso), 32'd0);
    check("load187_pedido",  32'(pedido),  32'd0);
    step(1'b0, 1'b1, 8'd30);
    check("over_estoque", 32'(estoque), 32'd200);
    check("over_excesso", 32'(excesso), 32'd1);
    step(1'b0, 1'b0, 8'd0);
    check("over_pulse_end", 32'(excesso), 32'd0);
    check("over_hold",      32'(estoque), 32'd200);
    step(1'b1, 1'b0, 8'd0);
    check("full_ve", 32'(estoque), 32'd199);
    step(1'b1, 1'b1, 8'd255);
    check("over_ve_estoque", 32'(estoque), 32'd199);
    check("over_ve_excesso", 32'(excesso), 32'd1);

    // async reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;

    // simultaneous load and withdrawal from empty
    step(1'b1, 1'b1, 8'd5);
    check("simul_estoque", 32'(estoque), 32'd4);
    check("simul_erro",    32'(erro),    32'd0);
    check("simul_rolha",   32'(rolha),   32'd1);
    check("simul_pedido",  32'(pedido),  32'd1);

    // zero-size load leaves stock unchanged
    step(1'b0, 1'b1, 8'd0);
    check("load0_estoque", 32'(estoque), 32'd4);
    check("load0_pedido",  32'(pedido),  32'd1);

    // underflow beats a zero-size load in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd0);
    check("drain4_estoque", 32'(estoque), 32'd0);
    step(1'b1, 1'b1, 8'd0);
    check("prio_erro", 32'(erro), 32'd1);
    step(1'b0, 1'b1, 8'd0);
    check("load0_keeps_erro", 32'(erro), 32'd1);
    step(1'b0, 1'b1, 8'd7);
    check("load7_erro",    32'(erro),    32'd0);
    check("load7_estoque", 32'(estoque), 32'd7);

    // reset held across an edge with a load pending: load is lost
    ve = 1'b0; carga = 1'b1; qtd_carga = 8'd100;
    reset = 1'b1;
    @(posedge clk);
    #1;
    carga = 1'b0; qtd_carga = 8'd0;
    check_reset_vals("rst_load");
    @(negedge clk);
    reset = 1'b0;

`ifdef ROLHA_TOTAL_EN
    step(1'b0, 1'b1, 8'd10);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'd0);
    check("tot_total",   32'(total),   32'd10);
    check("tot_erro",    32'(erro),    32'd1);
    check("tot_estoque", 32'(estoque), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_tot");
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
